avalon_ram_agent: RTL and testbench
===================================

Name: avalon_ram_agent

Overview:
- Avalon-MM agent (responder) backed by an on-chip word RAM.
- It is the target the MemoryUnit host drives over the AvalonMmRw interface.
- Accepts one read or write at a time, inserts a configurable number of wait states, and returns read data with waitrequest low and readdatavalid high in the same cycle.
- Writes honour per-byte lane enables. Sits between the core's load/store port and data memory in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; must be a power of two, at least 2.
- READ_WAIT, 1, wait cycles between accepting a read and responding (0 allowed).
- WRITE_WAIT, 0, wait cycles between accepting a write and acknowledging it (0 allowed).
- INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty means contents are undefined.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- port  interface  AvalonMmRw.Agent  bus port. Fields as seen from the agent:
  - port.read  input  1  read request, held by the host until completion.
  - port.write  input  1  write request, held by the host until completion.
  - port.address  input  32  byte address.
  - port.byteenable  input  4  lane enables; bit i selects byte lane i.
  - port.host_to_agent  input  32  write data.
  - port.agent_to_host  output  32  read data.
  - port.waitrequest  output  1  high while the command is not complete.
  - port.readdatavalid  output  1  high for exactly one cycle when read data is presented.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, wait counter=0, agent_to_host=0, readdatavalid=0, waitrequest=1.
  - RAM contents are not touched.
  - Reset during RD_WAIT or WR_WAIT abandons the transaction; a pending write is not committed.
- Word index = address[2 +: $clog2(DEPTH_WORDS)]. address[1:0] is ignored.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK.
- waitrequest = 1 in every state except RD_RESP and WR_ACK. readdatavalid = 1 only in RD_RESP.
- IDLE:
  - If read=1: latch address. Go to RD_WAIT with counter=READ_WAIT-1, or go directly to RD_RESP if READ_WAIT=0.
  - Else if write=1: latch address, byteenable and host_to_agent. Go to WR_WAIT with counter=WRITE_WAIT-1, or directly to WR_ACK if WRITE_WAIT=0.
  - If read and write are both high, read wins and the write is ignored; the host must re-present it.
- RD_WAIT: counter decrements each cycle. At the edge where the counter is 0, the RAM word is registered into agent_to_host and the state becomes RD_RESP.
- With READ_WAIT=0, the RAM word is registered on the IDLE->RD_RESP edge.
- RD_RESP: lasts one cycle, then returns to IDLE. agent_to_host holds its value until the next read response.
- WR_WAIT: counter decrements; at 0, go to WR_ACK.
- WR_ACK: lasts one cycle. At the edge leaving WR_ACK, each lane i with byteenable[i]=1 is written; other lanes keep their value. Then return to IDLE.
  - byteenable=0000 completes normally with no RAM change.
- Latency: a request first seen in IDLE at cycle N completes, with waitrequest=0, at cycle N+1+READ_WAIT for reads and N+1+WRITE_WAIT for writes.
- Back-to-back: if read or write is still high in the IDLE cycle after completion, it is accepted as a new transaction. Minimum spacing is 2 cycles per transaction.
- Request dropped before completion (a protocol violation): the agent completes anyway. A write still commits, and the state returns to IDLE.
- Read data is always the full 32-bit word; the host does sign/zero extension.
- Address and data changes while the agent is busy have no effect, because the command was latched at acceptance.

Optional Feature:
- Macro: AVALON_RAM_BOUNDS_CHECK_EN.
- Defined:
  - An access with address >= DEPTH_WORDS*4 still completes with normal timing.
  - Reads return 32'hDEADBEEF; writes are dropped.
  - A simulation $error is raised with the address.
- Undefined: the address is truncated to the index bits, so out-of-range accesses wrap modulo DEPTH_WORDS.

Test Plan:
- Reset with READ_WAIT=1: hold rst=1 for 2 cycles -> waitrequest=1, readdatavalid=0, agent_to_host=0. Then release rst with read=1 and address=0 -> RD_RESP 2 cycles after release.
- Word write/read: write 0x12345678 to address 0x10 with byteenable=1111, WRITE_WAIT=0.
  - waitrequest is low exactly one cycle after acceptance.
  - A read of 0x10 returns 0x12345678 with readdatavalid=1 and waitrequest=0 in the same single cycle.
- Byte lanes: word 0x20=0xAABBCCDD; write 0x00001122 with byteenable=0011 -> read returns 0xAABB1122.
  - Then write with byteenable=0000 -> read is unchanged.
- Wait states: READ_WAIT=3, WRITE_WAIT=2 -> read response 4 cycles after read rises; write ack 3 cycles after write rises. readdatavalid pulses exactly once per read.
- Corner cases:
  - read=1 and write=1 together in IDLE -> read serviced; RAM is unmodified.
  - rst asserted in WR_WAIT -> the target word keeps its old value.
- Bounds with DEPTH_WORDS=16, address 0x40:
  - AVALON_RAM_BOUNDS_CHECK_EN defined -> read returns 0xDEADBEEF.
  - Undefined -> read returns the word at address 0x00.

Source files
------------

// File: rtl/avalon_ram_agent.sv
// Avalon-MM agent backed by an on-chip 32-bit word RAM.
// One command at a time, configurable read/write wait states, byte-lane writes.
// Optional macro AVALON_RAM_BOUNDS_CHECK_EN: out-of-range accesses read
// 32'hDEADBEEF, drop writes and raise $error; otherwise addresses wrap.
module avalon_ram_agent #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WRITE_WAIT  = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        port_read_i,
  input  logic        port_write_i,
  input  logic [31:0] port_address_i,
  input  logic [3:0]  port_byteenable_i,
  input  logic [31:0] port_host_to_agent_i,
  output logic [31:0] port_agent_to_host_o,
  output logic        port_waitrequest_o,
  output logic        port_readdatavalid_o
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] RD_CNT0 = CW'((READ_WAIT  > 0) ? READ_WAIT  - 1 : 0);
  localparam logic [CW-1:0] WR_CNT0 = CW'((WRITE_WAIT > 0) ? WRITE_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_load;
  logic        wr_commit;
  logic        rd_oob;
  logic        wr_oob;
  logic        unused_addr_bits;

`ifdef AVALON_RAM_BOUNDS_CHECK_EN
  assign rd_oob  = |rd_addr[31:2+AW];
  assign wr_oob  = |addr_q[31:2+AW];
  assign rd_word = rd_oob ? 32'hDEADBEEF : mem_q[rd_addr[2 +: AW]];
`else
  assign rd_oob  = 1'b0;
  assign wr_oob  = 1'b0;
  assign rd_word = mem_q[rd_addr[2 +: AW]];
`endif

  assign unused_addr_bits = ^{rd_addr[31:2+AW], rd_addr[1:0], addr_q[31:2+AW],
                              addr_q[1:0], rd_oob};

  // With zero read wait the word is fetched on the accepting edge, so the
  // read index comes straight from the bus while idle.
  assign rd_addr = (state_q == IDLE) ? port_address_i : addr_q;

  // Next-state logic: command latching, wait counting, response selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (port_read_i) begin
          addr_d = port_address_i;
          if (READ_WAIT == 0) begin
            state_d = RD_RESP;
            rd_load = 1'b1;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_CNT0;
          end
        end else if (port_write_i) begin
          addr_d  = port_address_i;
          be_d    = port_byteenable_i;
          wdata_d = port_host_to_agent_i;
          if (WRITE_WAIT == 0) begin
            state_d = WR_ACK;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = WR_CNT0;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RD_RESP;
          rd_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_RESP: state_d = IDLE;
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_ACK: begin
        wr_commit = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata_d = rd_load ? rd_word : rdata_q;

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef AVALON_RAM_BOUNDS_CHECK_EN
      if (rd_load && rd_oob)   $error("avalon_ram_agent: read out of range at %h", rd_addr);
      if (wr_commit && wr_oob) $error("avalon_ram_agent: write out of range at %h", addr_q);
`endif
    end
  end

  // RAM write port: lane-masked commit on the edge leaving WR_ACK.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && !wr_oob) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[addr_q[2 +: AW]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign port_agent_to_host_o = rdata_q;
  assign port_readdatavalid_o = (state_q == RD_RESP);
  assign port_waitrequest_o   = !((state_q == RD_RESP) || (state_q == WR_ACK));

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Bench for avalon_ram_agent: two instances (small/fast and larger/slow)
// checked every cycle against a timestamp-based transaction model, plus
// directed literal expectations.
module tb_avalon_ram_agent;

  logic clk;
  logic [1:0] rst, rd, wr, wrq, rdv;
  logic [1:0][31:0] addr, wdat, rdat;
  logic [1:0][3:0]  ben;

  int passed = 0;
  int total  = 0;

  function automatic int dep(input int k); return (k == 0) ? 16 : 64; endfunction
  function automatic int rwt(input int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int wwt(input int k); return (k == 0) ? 0 : 2; endfunction

  avalon_ram_agent #(.DEPTH_WORDS(16), .READ_WAIT(1), .WRITE_WAIT(0)) u_a (
    .clk(clk), .rst(rst[0]),
    .port_read_i(rd[0]), .port_write_i(wr[0]), .port_address_i(addr[0]),
    .port_byteenable_i(ben[0]), .port_host_to_agent_i(wdat[0]),
    .port_agent_to_host_o(rdat[0]), .port_waitrequest_o(wrq[0]),
    .port_readdatavalid_o(rdv[0])
  );

  avalon_ram_agent #(.DEPTH_WORDS(64), .READ_WAIT(3), .WRITE_WAIT(2)) u_b (
    .clk(clk), .rst(rst[1]),
    .port_read_i(rd[1]), .port_write_i(wr[1]), .port_address_i(addr[1]),
    .port_byteenable_i(ben[1]), .port_host_to_agent_i(wdat[1]),
    .port_agent_to_host_o(rdat[1]), .port_waitrequest_o(wrq[1]),
    .port_readdatavalid_o(rdv[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Transaction model: completion cycle = acceptance cycle + 1 + wait.
  longint   cyc = 0;
  bit       mv [2], busy [2], m_isrd [2], pend_kn [2], exp_kn [2];
  longint   due [2];
  logic [31:0] m_a [2], m_d [2], pend [2], exp_rd [2];
  logic [3:0]  m_be [2];
  logic [31:0] mm [2][64];
  bit          kn [2][64];

  function automatic bit oob(input int k, input logic [31:0] a);
    return longint'(a) >= longint'(dep(k)) * 4;
  endfunction

  task automatic mread(input int k, input logic [31:0] a, output logic [31:0] v, output bit known);
    int idx;
    idx = int'((longint'(a) / 4) % dep(k));
    v = mm[k][idx];
    known = kn[k][idx];
`ifdef AVALON_RAM_BOUNDS_CHECK_EN
    if (oob(k, a)) begin v = 32'hDEADBEEF; known = 1'b1; end
`endif
  endtask

  task automatic mwrite(input int k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int idx;
    idx = int'((longint'(a) / 4) % dep(k));
`ifdef AVALON_RAM_BOUNDS_CHECK_EN
    if (oob(k, a)) return;
`endif
    for (int i = 0; i < 4; i++) if (be[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
    if (be == 4'hF) kn[k][idx] = 1'b1;
  endtask

  always @(posedge clk) begin
    longint c;
    c = cyc;
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        mv[k] = 1'b1; busy[k] = 1'b0; exp_rd[k] = '0; exp_kn[k] = 1'b1;
      end else if (mv[k]) begin
        if (busy[k]) begin
          if (c == due[k]) begin
            if (!m_isrd[k]) mwrite(k, m_a[k], m_be[k], m_d[k]);
            busy[k] = 1'b0;
          end
        end else if (rd[k] || wr[k]) begin
          busy[k] = 1'b1;
          m_isrd[k] = rd[k];
          m_a[k] = addr[k]; m_be[k] = ben[k]; m_d[k] = wdat[k];
          due[k] = c + 1 + (rd[k] ? rwt(k) : wwt(k));
          if (rd[k]) mread(k, addr[k], pend[k], pend_kn[k]);
        end
        if (busy[k] && m_isrd[k] && cyc == due[k]) begin
          exp_rd[k] = pend[k]; exp_kn[k] = pend_kn[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    bit done_now;
    for (int k = 0; k < 2; k++) begin
      if (mv[k]) begin
        done_now = busy[k] && (cyc == due[k]);
        chk($sformatf("waitrequest[%0d]", k), 32'(wrq[k]), 32'(!done_now));
        chk($sformatf("readdatavalid[%0d]", k), 32'(rdv[k]), 32'(done_now && m_isrd[k]));
        if (exp_kn[k]) chk($sformatf("agent_to_host[%0d]", k), rdat[k], exp_rd[k]);
      end
    end
  end

  // mode: 0 write, 1 read, 2 read+write together. lat = cycles after the
  // request cycle until waitrequest drops.
  task automatic xact(input int k, input int mode, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input bit rel, output int lat,
                      output logic [31:0] data, output int nv);
    bit done;
    int n;
    @(posedge clk); #2;
    if (rel) rst = '0;
    addr[k] = a; ben[k] = be; wdat[k] = d;
    rd[k] = (mode != 0); wr[k] = (mode != 1);
    n = 0; nv = 0; done = 1'b0; data = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n++;
      if (rdv[k]) nv++;
      if (!wrq[k]) begin
        done = 1'b1;
        data = rdat[k];
      end else if (n == 2) begin
        addr[k] = $urandom; wdat[k] = $urandom; ben[k] = 4'($urandom);
      end
    end
    if (!done) chk($sformatf("timeout[%0d]", k), 32'd0, 32'd1);
    lat = n - 1;
    @(posedge clk); #2;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  initial begin
    int lat, nv;
    logic [31:0] d;
    logic [31:0] bexp;
    rst = '1; rd = '0; wr = '0; addr = '0; wdat = '0; ben = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_waitrequest", 32'(wrq[k]), 32'd1);
      chk("reset_readdatavalid", 32'(rdv[k]), 32'd0);
      chk("reset_agent_to_host", rdat[k], 32'h0);
    end

    xact(0, 1, 32'h0, 4'hF, 32'h0, 1'b1, lat, d, nv);
    chk("rst_release_read_lat", lat, 32'd2);
    chk("rst_release_read_pulses", nv, 32'd1);

    xact(0, 0, 32'h10, 4'hF, 32'h12345678, 1'b0, lat, d, nv);
    chk("write_ww0_lat", lat, 32'd1);
    chk("write_no_rdv", nv, 32'd0);
    xact(0, 1, 32'h10, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("read_word_data", d, 32'h12345678);
    chk("read_rw1_lat", lat, 32'd2);
    chk("read_word_pulses", nv, 32'd1);

    xact(0, 0, 32'h20, 4'hF, 32'hAABBCCDD, 1'b0, lat, d, nv);
    xact(0, 0, 32'h20, 4'h3, 32'h00001122, 1'b0, lat, d, nv);
    xact(0, 1, 32'h20, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("byte_lanes_0011", d, 32'hAABB1122);
    xact(0, 0, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, lat, d, nv);
    chk("be0000_ack_lat", lat, 32'd1);
    xact(0, 1, 32'h22, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("byte_lanes_0000", d, 32'hAABB1122);

    xact(0, 2, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b0, lat, d, nv);
    chk("rd_wr_both_read_wins", d, 32'h12345678);
    chk("rd_wr_both_lat", lat, 32'd2);
    xact(0, 1, 32'h10, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("rd_wr_both_ram_kept", d, 32'h12345678);

    xact(0, 0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, lat, d, nv);
    xact(0, 1, 32'h40, 4'hF, 32'h0, 1'b0, lat, d, nv);
`ifdef AVALON_RAM_BOUNDS_CHECK_EN
    bexp = 32'hDEADBEEF;
`else
    bexp = 32'hCAFEF00D;
`endif
    chk("bounds_0x40", d, bexp);
    chk("bounds_lat", lat, 32'd2);

    xact(1, 0, 32'h30, 4'hF, 32'h55AA55AA, 1'b0, lat, d, nv);
    chk("write_ww2_lat", lat, 32'd3);
    xact(1, 1, 32'h30, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("read_rw3_lat", lat, 32'd4);
    chk("read_rw3_pulses", nv, 32'd1);
    chk("read_rw3_data", d, 32'h55AA55AA);

    // Reset lands while the write is still in its wait phase.
    @(posedge clk); #2;
    addr[1] = 32'h30; wdat[1] = 32'h0; ben[1] = 4'hF; wr[1] = 1'b1;
    @(posedge clk); #2;
    wr[1] = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #2;
    rst[1] = 1'b0;
    xact(1, 1, 32'h30, 4'hF, 32'h0, 1'b0, lat, d, nv);
    chk("rst_in_wr_wait_kept", d, 32'h55AA55AA);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
